segre_mem_arbiter: RTL and testbench

SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

---
 rtl/segre_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_segre_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter.sv
// Purpose: arbitrates icache refill, dcache refill and dcache writeback onto one lane-wide memory port.
// Latency: grant visible the cycle after the request is seen in IDLE; completion pulse the cycle after mem_ready_i.
// Backpressure: requests are level-held until their pulse; optional starvation guard via SEGRE_ARB_STARVE_GUARD_EN.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE    = 32,
    parameter int LANE_SIZE    = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ic_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    input  logic                 dc_req_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic                 wb_req_i,
    input  logic [ADDR_SIZE-1:0] wb_addr_i,
    input  logic [LANE_SIZE-1:0] wb_data_i,
    output logic                 ic_rdy_o,
    output logic                 dc_rdy_o,
    output logic                 wb_done_o,
    output logic [LANE_SIZE-1:0] rd_data_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LANE_SIZE-1:0] mem_data_o,
    input  logic [LANE_SIZE-1:0] mem_data_i,
    input  logic                 mem_ready_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_REQ = 3'd1,
        DC_REQ = 3'd2,
        IC_REQ = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   grant_wb;
    logic   grant_dc;
    logic   grant_ic;
    logic   starve_hit;

`ifdef SEGRE_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

    logic [CNT_W-1:0] starve_cnt_q;

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Counts data-side grants that bypassed a waiting icache request.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            starve_cnt_q <= '0;
        end else if (grant_ic) begin
            starve_cnt_q <= '0;
        end else if ((grant_wb || grant_dc) && ic_req_i && !starve_hit) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        grant_wb = 1'b0;
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if (state_q == IDLE) begin
            if (starve_hit && ic_req_i) begin
                grant_ic = 1'b1;
            end else if (wb_req_i) begin
                grant_wb = 1'b1;
            end else if (dc_req_i) begin
                grant_dc = 1'b1;
            end else if (ic_req_i) begin
                grant_ic = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_wb) begin
                    state_d = WB_REQ;
                end else if (grant_dc) begin
                    state_d = DC_REQ;
                end else if (grant_ic) begin
                    state_d = IC_REQ;
                end
            end
            WB_REQ, DC_REQ, IC_REQ: begin
                if (mem_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs and pulses are all registered so requester changes never glitch them.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q    <= IDLE;
            mem_rd_o   <= 1'b0;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            rd_data_o  <= '0;
            ic_rdy_o   <= 1'b0;
            dc_rdy_o   <= 1'b0;
            wb_done_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_rd_o  <= (state_d == DC_REQ) || (state_d == IC_REQ);
            mem_wr_o  <= (state_d == WB_REQ);
            wb_done_o <= (state_q == WB_REQ) && mem_ready_i;
            dc_rdy_o  <= (state_q == DC_REQ) && mem_ready_i;
            ic_rdy_o  <= (state_q == IC_REQ) && mem_ready_i;
            if (grant_wb) begin
                mem_addr_o <= wb_addr_i;
                mem_data_o <= wb_data_i;
            end else if (grant_dc) begin
                mem_addr_o <= dc_addr_i;
            end else if (grant_ic) begin
                mem_addr_o <= ic_addr_i;
            end
            if (((state_q == DC_REQ) || (state_q == IC_REQ)) && mem_ready_i) begin
                rd_data_o <= mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: hand-computed expectations for grants, pulses and reset behaviour.
module tb_segre_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk_i = 1'b0;
    logic          rsn_i;
    logic          ic_req_i;
    logic [AW-1:0] ic_addr_i;
    logic          dc_req_i;
    logic [AW-1:0] dc_addr_i;
    logic          wb_req_i;
    logic [AW-1:0] wb_addr_i;
    logic [LW-1:0] wb_data_i;
    logic          ic_rdy_o;
    logic          dc_rdy_o;
    logic          wb_done_o;
    logic [LW-1:0] rd_data_o;
    logic          mem_rd_o;
    logic          mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_data_o;
    logic [LW-1:0] mem_data_i;
    logic          mem_ready_i;
    logic [2:0]    pulses;

    int n_cmp = 0;
    int n_err = 0;

    assign pulses = {wb_done_o, dc_rdy_o, ic_rdy_o};

    always #5 clk_i = ~clk_i;

    segre_mem_arbiter #(
        .ADDR_SIZE    (AW),
        .LANE_SIZE    (LW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i       (clk_i),
        .rsn_i       (rsn_i),
        .ic_req_i    (ic_req_i),
        .ic_addr_i   (ic_addr_i),
        .dc_req_i    (dc_req_i),
        .dc_addr_i   (dc_addr_i),
        .wb_req_i    (wb_req_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .ic_rdy_o    (ic_rdy_o),
        .dc_rdy_o    (dc_rdy_o),
        .wb_done_o   (wb_done_o),
        .rd_data_o   (rd_data_o),
        .mem_rd_o    (mem_rd_o),
        .mem_wr_o    (mem_wr_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ready_i (mem_ready_i)
    );

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (!(mem_rd_o || mem_wr_o) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_grant"}, LW'(mem_rd_o | mem_wr_o), LW'(1));
    endtask

    // Waits for a grant, checks it, answers it, checks the single completion pulse and drops that request.
    task automatic serve(input string tag, input logic exp_wr, input logic [AW-1:0] exp_addr,
                         input logic [LW-1:0] exp_wdata, input logic [LW-1:0] rdata,
                         input logic [2:0] exp_pulse);
        wait_grant(tag);
        chk({tag, "_wr"}, LW'(mem_wr_o), LW'(exp_wr));
        chk({tag, "_rd"}, LW'(mem_rd_o), LW'(!exp_wr));
        chk({tag, "_addr"}, LW'(mem_addr_o), LW'(exp_addr));
        if (exp_wr) chk({tag, "_wdata"}, mem_data_o, exp_wdata);
        mem_ready_i = 1'b1;
        mem_data_i  = rdata;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        chk({tag, "_pulse"}, LW'(pulses), LW'(exp_pulse));
        chk({tag, "_memoff"}, LW'({mem_rd_o, mem_wr_o}), LW'(0));
        if (!exp_wr) chk({tag, "_rdata"}, rd_data_o, rdata);
        if (exp_pulse[2]) wb_req_i = 1'b0;
        if (exp_pulse[1]) dc_req_i = 1'b0;
        if (exp_pulse[0]) ic_req_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_onepulse"}, LW'(pulses), LW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] pat_a5;
        logic [LW-1:0] pat_wb;
        int            dc_grants;
        logic          ic_seen;

        pat_a5      = {16{8'hA5}};
        pat_wb      = {4{32'hDEADBEEF}};
        rsn_i       = 1'b0;
        ic_req_i    = 1'b0;
        ic_addr_i   = '0;
        dc_req_i    = 1'b0;
        dc_addr_i   = '0;
        wb_req_i    = 1'b0;
        wb_addr_i   = '0;
        wb_data_i   = '0;
        mem_data_i  = '0;
        mem_ready_i = 1'b0;

        #12;
        chk("rst_memrw", LW'({mem_rd_o, mem_wr_o}), LW'(0));
        chk("rst_pulses", LW'(pulses), LW'(0));
        chk("rst_addr", LW'(mem_addr_o), LW'(0));
        chk("rst_wdata", mem_data_o, LW'(0));
        chk("rst_rdata", rd_data_o, LW'(0));
        @(negedge clk_i);
        rsn_i = 1'b1;
        @(negedge clk_i);

        // Single icache refill with exact-cycle checks.
        ic_req_i  = 1'b1;
        ic_addr_i = 32'h100;
        @(negedge clk_i);
        chk("ic_rd_n1", LW'(mem_rd_o), LW'(1));
        chk("ic_wr_n1", LW'(mem_wr_o), LW'(0));
        chk("ic_addr_n1", LW'(mem_addr_o), LW'(32'h100));
        repeat (2) @(negedge clk_i);
        chk("ic_rd_hold", LW'(mem_rd_o), LW'(1));
        @(negedge clk_i);
        mem_ready_i = 1'b1;
        mem_data_i  = pat_a5;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        mem_data_i  = '0;
        chk("ic_pulse", LW'(pulses), LW'(3'b001));
        chk("ic_rdata", rd_data_o, pat_a5);
        chk("ic_memoff", LW'(mem_rd_o), LW'(0));
        ic_req_i = 1'b0;
        @(negedge clk_i);
        chk("ic_onepulse", LW'(pulses), LW'(0));
        chk("ic_rdata_hold", rd_data_o, pat_a5);
        @(negedge clk_i);
        chk("ic_no_regrant", LW'({mem_rd_o, mem_wr_o}), LW'(0));

        // All three at once, writeback and dcache refill to the same lane.
        wb_req_i  = 1'b1;
        wb_addr_i = 32'h200;
        wb_data_i = pat_wb;
        dc_req_i  = 1'b1;
        dc_addr_i = 32'h200;
        ic_req_i  = 1'b1;
        ic_addr_i = 32'h300;
        serve("prio_wb", 1'b1, 32'h200, pat_wb, '0, 3'b100);
        serve("prio_dc", 1'b0, 32'h200, '0, {4{32'h11112222}}, 3'b010);
        serve("prio_ic", 1'b0, 32'h300, '0, {4{32'h33334444}}, 3'b001);

        // dcache drops its request right after the grant.
        dc_req_i  = 1'b1;
        dc_addr_i = 32'h400;
        @(negedge clk_i);
        chk("drop_grant", LW'(mem_rd_o), LW'(1));
        dc_req_i = 1'b0;
        @(negedge clk_i);
        chk("drop_rd_held", LW'(mem_rd_o), LW'(1));
        chk("drop_addr", LW'(mem_addr_o), LW'(32'h400));
        mem_ready_i = 1'b1;
        mem_data_i  = {4{32'h55556666}};
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        chk("drop_pulse", LW'(pulses), LW'(3'b010));
        chk("drop_rdata", rd_data_o, {4{32'h55556666}});
        @(negedge clk_i);
        chk("drop_onepulse", LW'(pulses), LW'(0));
        @(negedge clk_i);
        chk("drop_no_regrant", LW'(mem_rd_o), LW'(0));

        // Reset in the middle of a dcache refill.
        dc_req_i  = 1'b1;
        dc_addr_i = 32'h500;
        @(negedge clk_i);
        chk("rstmid_grant", LW'(mem_rd_o), LW'(1));
        #2;
        rsn_i = 1'b0;
        #1;
        chk("rstmid_rd_drop", LW'(mem_rd_o), LW'(0));
        chk("rstmid_addr", LW'(mem_addr_o), LW'(0));
        @(negedge clk_i);
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        chk("rstmid_no_pulse", LW'(pulses), LW'(0));
        rsn_i = 1'b1;
        serve("rstmid_regrant", 1'b0, 32'h500, '0, {4{32'hCAFEF00D}}, 3'b010);

        // Stray mem_ready_i in IDLE.
        mem_ready_i = 1'b1;
        mem_data_i  = '1;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        chk("stray_memrw", LW'({mem_rd_o, mem_wr_o}), LW'(0));
        chk("stray_pulses", LW'(pulses), LW'(0));
        chk("stray_rdata", rd_data_o, {4{32'hCAFEF00D}});
        chk("stray_addr", LW'(mem_addr_o), LW'(32'h500));
        @(negedge clk_i);
        chk("stray_pulses2", LW'(pulses), LW'(0));

        // icache waiting behind a continuous dcache stream.
        dc_grants = 0;
        ic_seen   = 1'b0;
        dc_req_i  = 1'b1;
        dc_addr_i = 32'h600;
        ic_req_i  = 1'b1;
        ic_addr_i = 32'h700;
        for (int g = 0; g < 6; g++) begin
            if (!ic_seen) begin
                wait_grant("starve");
                if (mem_rd_o && mem_addr_o == 32'h700) ic_seen = 1'b1;
                else if (mem_rd_o) dc_grants++;
                mem_ready_i = 1'b1;
                @(negedge clk_i);
                mem_ready_i = 1'b0;
            end
        end
        dc_req_i = 1'b0;
        ic_req_i = 1'b0;
`ifdef SEGRE_ARB_STARVE_GUARD_EN
        chk("starve_ic_seen", LW'(ic_seen), LW'(1));
        chk("starve_dc_before_ic", LW'(dc_grants), LW'(4));
`else
        chk("starve_ic_seen", LW'(ic_seen), LW'(0));
        chk("starve_dc_grants", LW'(dc_grants), LW'(6));
`endif
        repeat (2) @(negedge clk_i);
        chk("final_idle", LW'({mem_rd_o, mem_wr_o}), LW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
